kamikaze_fetch: RTL and testbench

- Instruction-fetch stage sitting directly upstream of kamikaze_decode; drives its instr_i / instr_valid_i / pc_i / is_compressed_instr_i inputs.
- Issues word-aligned reads on a single-outstanding req/ack instruction-memory port.
- Realigns the 16-bit-granular RV32IC instruction stream into one instruction per output beat.
- Handles pipeline stall and branch/jump redirect.

---
 rtl/kamikaze_fetch_pkg.sv | 18 +
 rtl/kamikaze_fetch_align.sv | 140 ++++++++++++++
 rtl/kamikaze_fetch.sv | 137 +++++++++++++
 tb/tb_kamikaze_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kamikaze_fetch_pkg.sv
// Shared constants and types for the kamikaze instruction-fetch stage.
// Halfword length decode follows the RV32IC encoding.
package kamikaze_fetch_pkg;

    localparam logic [1:0]  INSTR_LEN32  = 2'b11;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic {
        ST_RUN,
        ST_KILL
    } fetch_state_e;

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != INSTR_LEN32;
    endfunction

endpackage

// File: rtl/kamikaze_fetch_align.sv
// Halfword realignment: turns fetched words into one instruction per beat.
// Owns the halfword buffer, the instruction PC and the output slot.
module kamikaze_fetch_align
    import kamikaze_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        stall,
    input  logic        word_valid,
    input  logic        word_skip,
    input  logic [31:0] word_data,
    output logic        consume,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        is_compressed,
    output logic [31:0] pc
);

    logic [15:0] hbuf_q;
    logic [15:0] hbuf_d;
    logic        hbuf_v_q;
    logic        hbuf_v_d;
    logic [31:0] pc_q;
    logic [31:0] pc_step;
    logic        slot_free;
    logic        emit;
    logic        emit_c;
    logic [31:0] emit_instr;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        h_c;
    logic        h_w;
    logic        w_c;
    logic        w_w;
    logic        s_c;
    logic        s_w;
    logic        w_full;
    logic        w_half;

    assign slot_free = !instr_valid || !stall;
    assign lo        = word_data[15:0];
    assign hi        = word_data[31:16];

    // mutually exclusive assembly cases, highest priority first
    assign w_full = !hbuf_v_q && word_valid && !word_skip;
    assign w_half = !hbuf_v_q && word_valid && word_skip;
    assign h_c    = hbuf_v_q && is_rvc(hbuf_q);
    assign h_w    = hbuf_v_q && !is_rvc(hbuf_q) && word_valid;
    assign w_c    = w_full && is_rvc(lo);
    assign w_w    = w_full && !is_rvc(lo);
    assign s_c    = w_half && is_rvc(hi);
    assign s_w    = w_half && !is_rvc(hi);

    always_comb begin
        hbuf_d     = hbuf_q;
        hbuf_v_d   = hbuf_v_q;
        pc_step    = 32'd0;
        emit       = 1'b0;
        emit_c     = 1'b0;
        emit_instr = 32'd0;
        consume    = 1'b0;
        if (slot_free && !flush) begin
            unique case (1'b1)
                h_c: begin
                    emit       = 1'b1;
                    emit_c     = 1'b1;
                    emit_instr = {16'h0, hbuf_q};
                    hbuf_v_d   = 1'b0;
                    pc_step    = 32'd2;
                end
                h_w: begin
                    emit       = 1'b1;
                    emit_instr = {lo, hbuf_q};
                    hbuf_d     = hi;
                    consume    = 1'b1;
                    pc_step    = 32'd4;
                end
                w_c: begin
                    emit       = 1'b1;
                    emit_c     = 1'b1;
                    emit_instr = {16'h0, lo};
                    hbuf_d     = hi;
                    hbuf_v_d   = 1'b1;
                    consume    = 1'b1;
                    pc_step    = 32'd2;
                end
                w_w: begin
                    emit       = 1'b1;
                    emit_instr = word_data;
                    consume    = 1'b1;
                    pc_step    = 32'd4;
                end
                s_c: begin
                    emit       = 1'b1;
                    emit_c     = 1'b1;
                    emit_instr = {16'h0, hi};
                    consume    = 1'b1;
                    pc_step    = 32'd2;
                end
                s_w: begin
                    hbuf_d   = hi;
                    hbuf_v_d = 1'b1;
                    consume  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hbuf_q        <= 16'h0;
            hbuf_v_q      <= 1'b0;
            pc_q          <= RESET_PC & ~32'd1;
            instr         <= 32'd0;
            instr_valid   <= 1'b0;
            is_compressed <= 1'b0;
            pc            <= 32'd0;
        end else if (flush) begin
            hbuf_v_q    <= 1'b0;
            instr_valid <= 1'b0;
            pc_q        <= flush_pc & ~32'd1;
        end else if (slot_free) begin
            hbuf_q      <= hbuf_d;
            hbuf_v_q    <= hbuf_v_d;
            pc_q        <= pc_q + pc_step;
            instr_valid <= emit;
            if (emit) begin
                instr         <= emit_instr;
                is_compressed <= emit_c;
                pc            <= pc_q;
            end
        end
    end

endmodule

// File: rtl/kamikaze_fetch.sv
// Instruction-fetch stage: single-outstanding imem handshake, response
// buffer and redirect kill tracking around the halfword aligner.
module kamikaze_fetch
    import kamikaze_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        is_compressed_instr_o,
    output logic [31:0] pc_o
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic        pending_q;
    logic [31:0] req_addr_q;
    logic [31:0] fetch_addr_q;
    logic        rbuf_v_q;
    logic        rbuf_skip_q;
    logic [31:0] rbuf_q;
    logic        skip_next_q;
    logic        run;
    logic        ack_run;
    logic        word_v;
    logic        word_skip;
    logic [31:0] word_data;
    logic        consume;

    assign run     = state_q == ST_RUN;
    assign ack_run = imem_ack_i && run && !redirect_i;

    // a word acked this cycle bypasses rbuf straight into the aligner
    assign word_v    = rbuf_v_q || ack_run;
    assign word_data = rbuf_v_q ? rbuf_q : imem_rdata_i;
    assign word_skip = rbuf_v_q ? rbuf_skip_q : skip_next_q;

    assign imem_req_o = rst_i &&
        (pending_q || (run && (!rbuf_v_q || consume) && !redirect_i));
    assign imem_addr_o = pending_q ? req_addr_q : fetch_addr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_i && pending_q && !imem_ack_i) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                if (imem_ack_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending_q    <= 1'b0;
            req_addr_q   <= RESET_PC & ~32'd3;
            fetch_addr_q <= RESET_PC & ~32'd3;
        end else begin
            pending_q <= imem_req_o && !imem_ack_i;
            if (imem_req_o && !pending_q) begin
                req_addr_q <= fetch_addr_q;
            end
            if (redirect_i) begin
                fetch_addr_q <= redirect_pc_i & ~32'd3;
            end else if (ack_run) begin
                fetch_addr_q <= fetch_addr_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rbuf_q      <= 32'd0;
            rbuf_v_q    <= 1'b0;
            rbuf_skip_q <= 1'b0;
            skip_next_q <= 1'b0;
        end else begin
            if (redirect_i) begin
                rbuf_v_q <= 1'b0;
            end else if (ack_run && (rbuf_v_q || !consume)) begin
                rbuf_q      <= imem_rdata_i;
                rbuf_v_q    <= 1'b1;
                rbuf_skip_q <= skip_next_q;
            end else if (consume) begin
                rbuf_v_q <= 1'b0;
            end
            if (redirect_i) begin
                skip_next_q <= redirect_pc_i[1];
            end else if (ack_run) begin
                skip_next_q <= 1'b0;
            end
        end
    end

    kamikaze_fetch_align #(
        .RESET_PC(RESET_PC)
    ) u_align (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush        (redirect_i),
        .flush_pc     (redirect_pc_i),
        .stall        (stall_i),
        .word_valid   (word_v),
        .word_skip    (word_skip),
        .word_data    (word_data),
        .consume      (consume),
        .instr        (instr_o),
        .instr_valid  (instr_valid_o),
        .is_compressed(is_compressed_instr_o),
        .pc           (pc_o)
    );

endmodule

// File: tb/tb_kamikaze_fetch.sv
// Directed bench for kamikaze_fetch with a simple wait-state memory model.
module tb_kamikaze_fetch;
    import kamikaze_fetch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        is_compressed_instr_o;
    logic [31:0] pc_o;

    int tests = 0;
    int failed = 0;
    int delay = 0;
    int cnt = 0;
    int base = 0;
    logic [31:0] mem [0:127];
    logic [31:0] acks [$];

    kamikaze_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .imem_req_o           (imem_req_o),
        .imem_addr_o          (imem_addr_o),
        .imem_ack_i           (imem_ack_i),
        .imem_rdata_i         (imem_rdata_i),
        .stall_i              (stall_i),
        .redirect_i           (redirect_i),
        .redirect_pc_i        (redirect_pc_i),
        .instr_o              (instr_o),
        .instr_valid_o        (instr_valid_o),
        .is_compressed_instr_o(is_compressed_instr_o),
        .pc_o                 (pc_o)
    );

    always #5 clk_i = ~clk_i;

    // memory: decides the ack just after each falling edge
    always begin
        @(posedge clk_i);
        #1 imem_ack_i = 1'b0;
        @(negedge clk_i);
        #1;
        if (imem_req_o) begin
            if (cnt >= delay) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem[imem_addr_o[8:2]];
                acks.push_back(imem_addr_o);
                cnt = 0;
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ack_at(input int i);
        if (i < acks.size()) return acks[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic fill_nop();
        for (int i = 0; i < 128; i++) mem[i] = NOP_INSTR;
    endtask

    task automatic do_reset();
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        rst_i         = 1'b1;
        #1 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        base = acks.size();
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'd0;
        tick();

        // two 32-bit instructions, zero wait
        fill_nop();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        delay = 0;
        do_reset();
        chk("rst req", {31'd0, imem_req_o}, 32'd0);
        chk("rst addr", imem_addr_o, 32'd0);
        chk("rst valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst instr", instr_o, 32'd0);
        chk("rst pc", pc_o, 32'd0);
        chk("rst cmp", {31'd0, is_compressed_instr_o}, 32'd0);
        rst_i = 1'b1;
        tick();
        chk("s1 valid0", {31'd0, instr_valid_o}, 32'd1);
        chk("s1 instr0", instr_o, 32'h0050_0093);
        chk("s1 pc0", pc_o, 32'h0);
        chk("s1 cmp0", {31'd0, is_compressed_instr_o}, 32'd0);
        tick();
        chk("s1 valid1", {31'd0, instr_valid_o}, 32'd1);
        chk("s1 instr1", instr_o, 32'h00A0_0113);
        chk("s1 pc1", pc_o, 32'h4);
        chk("s1 cmp1", {31'd0, is_compressed_instr_o}, 32'd0);

        // two compressed instructions in one word
        fill_nop();
        mem[0] = 32'h0001_4505;
        do_reset();
        rst_i = 1'b1;
        tick();
        chk("s2 instr0", instr_o, 32'h0000_4505);
        chk("s2 pc0", pc_o, 32'h0);
        chk("s2 cmp0", {31'd0, is_compressed_instr_o}, 32'd1);
        tick();
        chk("s2 valid1", {31'd0, instr_valid_o}, 32'd1);
        chk("s2 instr1", instr_o, 32'h0000_0001);
        chk("s2 pc1", pc_o, 32'h2);
        chk("s2 cmp1", {31'd0, is_compressed_instr_o}, 32'd1);
        chk("s2 addr0", ack_at(base), 32'h0);
        chk("s2 addr1", ack_at(base + 1), 32'h4);

        // 32-bit instruction straddling a word boundary
        fill_nop();
        mem[0] = 32'h0093_4505;
        mem[1] = 32'h0001_0050;
        do_reset();
        rst_i = 1'b1;
        tick();
        chk("s3 instr0", instr_o, 32'h0000_4505);
        chk("s3 cmp0", {31'd0, is_compressed_instr_o}, 32'd1);
        tick();
        chk("s3 valid1", {31'd0, instr_valid_o}, 32'd1);
        chk("s3 instr1", instr_o, 32'h0050_0093);
        chk("s3 pc1", pc_o, 32'h2);
        chk("s3 cmp1", {31'd0, is_compressed_instr_o}, 32'd0);

        // redirect during a slow request, resume from the upper half
        fill_nop();
        mem[4]    = 32'h1234_5678;
        mem[7'h40] = 32'h4505_0093;
        delay = 3;
        do_reset();
        rst_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h10;
        tick();
        redirect_i = 1'b0;
        tick();
        chk("s4 req pend", {31'd0, imem_req_o}, 32'd1);
        chk("s4 addr pend", imem_addr_o, 32'h10);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h102;
        tick();
        redirect_i = 1'b0;
        chk("s4 kill req", {31'd0, imem_req_o}, 32'd1);
        chk("s4 kill addr", imem_addr_o, 32'h10);
        chk("s4 kill valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("s4 hold addr", imem_addr_o, 32'h10);
        delay = 0;
        tick();
        chk("s4 drop", {31'd0, instr_valid_o}, 32'd0);
        chk("s4 new req", {31'd0, imem_req_o}, 32'd1);
        chk("s4 new addr", imem_addr_o, 32'h100);
        chk("s4 ack0", ack_at(base), 32'h10);
        tick();
        chk("s4 valid", {31'd0, instr_valid_o}, 32'd1);
        chk("s4 pc", pc_o, 32'h102);
        chk("s4 instr", instr_o, 32'h0000_4505);
        chk("s4 cmp", {31'd0, is_compressed_instr_o}, 32'd1);
        chk("s4 ack1", ack_at(base + 1), 32'h100);

        // stall with a response arriving
        fill_nop();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h00F0_0193;
        do_reset();
        rst_i = 1'b1;
        tick();
        chk("s5 pc0", pc_o, 32'h0);
        stall_i = 1'b1;
        tick();
        chk("s5 hold instr", instr_o, 32'h0050_0093);
        chk("s5 hold valid", {31'd0, instr_valid_o}, 32'd1);
        #2 chk("s5 no req", {31'd0, imem_req_o}, 32'd0);
        tick();
        chk("s5 hold pc", pc_o, 32'h0);
        tick();
        chk("s5 hold instr2", instr_o, 32'h0050_0093);
        tick();
        chk("s5 hold pc2", pc_o, 32'h0);
        chk("s5 acks", acks.size() - base, 32'd2);
        stall_i = 1'b0;
        tick();
        chk("s5 next instr", instr_o, 32'h00A0_0113);
        chk("s5 next pc", pc_o, 32'h4);
        chk("s5 next valid", {31'd0, instr_valid_o}, 32'd1);

        // reset asserted while a request waits
        fill_nop();
        mem[0] = 32'h0050_0093;
        delay = 0;
        do_reset();
        rst_i = 1'b1;
        tick();
        stall_i = 1'b1;
        delay = 5;
        tick();
        chk("s6 req", {31'd0, imem_req_o}, 32'd1);
        chk("s6 valid", {31'd0, instr_valid_o}, 32'd1);
        #3 rst_i = 1'b0;
        #1;
        chk("s6 async req", {31'd0, imem_req_o}, 32'd0);
        chk("s6 async valid", {31'd0, instr_valid_o}, 32'd0);
        chk("s6 async addr", imem_addr_o, 32'h0);
        stall_i = 1'b0;
        delay = 0;
        tick();
        base = acks.size();
        rst_i = 1'b1;
        tick();
        chk("s6 first addr", ack_at(base), 32'h0);
        chk("s6 pc", pc_o, 32'h0);
        chk("s6 instr", instr_o, 32'h0050_0093);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
